ptp_delay_req_sched: RTL and testbench

Slave-side PTP exchange scheduler in the eth_tx_clk_125m domain. Upstream is the PTP receive parser, which delivers Sync, Follow_Up and Delay_Resp event pulses. This block runs the Sync → Follow_Up → Delay_Req → Delay_Resp exchange and decides when a Delay_Req frame goes out. It also arbitrates the single Ethernet TX path between the Delay_Req generator and a general UDP requester, and emits a calculate strobe once t1..t4 are all captured.

---
 rtl/ptp_pkg.sv | 24 ++
 rtl/ptp_tx_arb.sv | 80 ++++++++
 rtl/ptp_delay_req_sched.sv | 143 ++++++++++++++
 tb/tb_ptp_delay_req_sched.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ptp_pkg.sv
// Shared encodings for the PTP Delay_Req scheduler: the exchange FSM states
// and the owner of the single Ethernet TX path.
package ptp_pkg;

    // Exchange FSM states; the numeric values are visible on the debug port.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_FUP  = 3'd1,
        ST_TX_PEND   = 3'd2,
        ST_TX_BUSY   = 3'd3,
        ST_WAIT_RESP = 3'd4,
        ST_DONE      = 3'd5
    } ptp_state_e;

    // Current owner of the TX path.
    typedef enum logic [1:0] {
        OWN_FREE = 2'd0,
        OWN_UDP  = 2'd1,
        OWN_PTP  = 2'd2
    } tx_owner_e;

    localparam int TIMER_W = 32;

endpackage

// File: rtl/ptp_tx_arb.sv
// Two-requester arbiter for the single Ethernet TX path. Grants happen only
// while the path is free, are announced by a same-cycle start pulse, and last
// until the MAC reports tx_done. On a tie the requester that was not granted
// last time wins.
module ptp_tx_arb
    import ptp_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic ptp_req_i,
    input  logic udp_req_i,
    input  logic tx_done_i,
    output logic ptp_gnt_o,
    output logic udp_gnt_o,
    output logic tx_sel_o,
    output logic tx_start_o
);

    tx_owner_e owner_q, owner_d;
    logic      last_ptp_q, last_ptp_d;
    logic      sel_q, sel_d;
    logic      ptp_win, udp_win;

    // Grant decision and ownership next-state.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        ptp_win    = 1'b0;
        udp_win    = 1'b0;
        owner_d    = owner_q;
        last_ptp_d = last_ptp_q;
        sel_d      = sel_q;

        // NOTE: the grant is combinational, so it is masked by the async reset
        // to keep a held udp_req from producing a start pulse during reset.
        if (owner_q == OWN_FREE && !rst_i) begin
            if (ptp_req_i && udp_req_i) begin
                if (last_ptp_q) udp_win = 1'b1;
                else            ptp_win = 1'b1;
            end else if (ptp_req_i) begin
                ptp_win = 1'b1;
            end else if (udp_req_i) begin
                udp_win = 1'b1;
            end
        end

        if (ptp_win) begin
            owner_d    = OWN_PTP;
            last_ptp_d = 1'b1;
            sel_d      = 1'b1;
        end else if (udp_win) begin
            owner_d    = OWN_UDP;
            last_ptp_d = 1'b0;
            sel_d      = 1'b0;
        end else if (owner_q != OWN_FREE && tx_done_i) begin
            owner_d = OWN_FREE;
        end
    end

    // Ownership, fairness history and mux select registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples its pre-edge inputs regardless of statement order.
        if (rst_i) begin
            owner_q    <= OWN_FREE;
            last_ptp_q <= 1'b0;
            sel_q      <= 1'b0;
        end else begin
            owner_q    <= owner_d;
            last_ptp_q <= last_ptp_d;
            sel_q      <= sel_d;
        end
    end

    assign ptp_gnt_o  = ptp_win;
    assign udp_gnt_o  = udp_win | (owner_q == OWN_UDP);
    assign tx_sel_o   = ptp_win | (~udp_win & sel_q);
    assign tx_start_o = ptp_win | udp_win;

endmodule

// File: rtl/ptp_delay_req_sched.sv
// Slave-side PTP exchange scheduler: runs Sync -> Follow_Up -> Delay_Req ->
// Delay_Resp, requests the TX path for the Delay_Req frame, and strobes
// calc_en once t1..t4 are captured.
// Optional feature: define PTP_SEQ_CHECK_EN to accept a Delay_Resp only when
// its sequence id matches the id of the last Delay_Req sent.
module ptp_delay_req_sched
    import ptp_pkg::*;
#(
    parameter logic [TIMER_W-1:0] TIMEOUT_CYC = 32'd125_000_000,
    parameter int                 SEQ_W       = 16
) (
    input  logic             eth_tx_clk_125m,
    input  logic             rst,
    input  logic             sync_rx,
    input  logic             fup_rx,
    input  logic             resp_rx,
    input  logic [SEQ_W-1:0] resp_seqid,
    input  logic             udp_req,
    input  logic             tx_done,
    output logic             udp_gnt,
    output logic             tx_sel,
    output logic             tx_start_en,
    output logic [SEQ_W-1:0] sequenceid,
    output logic             t3_latch,
    output logic             calc_en,
    output logic             timeout_err,
    output logic [2:0]       ptp_state
);

    ptp_state_e         state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [SEQ_W-1:0]   seq_q, seq_d;
    logic               ptp_req_q, ptp_req_d;
    logic               ptp_gnt;
    logic               resp_ok;
    logic               expired;
    logic               timer_clr;
    logic               tout;

`ifdef PTP_SEQ_CHECK_EN
    assign resp_ok = resp_rx && (resp_seqid == seq_q);
`else
    logic unused_resp_seqid;
    assign resp_ok           = resp_rx;
    assign unused_resp_seqid = ^resp_seqid;
`endif

    assign expired = (timer_q == TIMEOUT_CYC - 32'd1);

    // Exchange next-state, timer restart and timeout pulse.
    always_comb begin
        state_d   = state_q;
        timer_clr = 1'b0;
        tout      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sync_rx) state_d = ST_WAIT_FUP;
            end
            ST_WAIT_FUP: begin
                if (fup_rx) begin
                    state_d = ST_TX_PEND;
                end else if (sync_rx) begin
                    timer_clr = 1'b1;
                end else if (expired) begin
                    state_d = ST_IDLE;
                    tout    = 1'b1;
                end
            end
            ST_TX_PEND: begin
                if (ptp_gnt) state_d = ST_TX_BUSY;
            end
            ST_TX_BUSY: begin
                if (tx_done) state_d = ST_WAIT_RESP;
            end
            ST_WAIT_RESP: begin
                if (resp_ok) begin
                    state_d = ST_DONE;
                end else if (sync_rx) begin
                    state_d = ST_WAIT_FUP;
                end else if (expired) begin
                    state_d = ST_IDLE;
                    tout    = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Shared wait timer, sequence counter and the registered PTP request.
    always_comb begin
        if (state_d != state_q || timer_clr) begin
            timer_d = '0;
        end else if (state_q == ST_WAIT_FUP || state_q == ST_WAIT_RESP) begin
            timer_d = timer_q + 32'd1;
        end else begin
            timer_d = '0;
        end

        seq_d = seq_q;
        if (state_q == ST_TX_PEND && ptp_gnt) seq_d = seq_q + 1'b1;

        ptp_req_d = (state_q == ST_TX_PEND) && !ptp_gnt;
    end

    // Exchange state registers.
    always_ff @(posedge eth_tx_clk_125m or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            seq_q     <= '0;
            ptp_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            seq_q     <= seq_d;
            ptp_req_q <= ptp_req_d;
        end
    end

    ptp_tx_arb u_arb (
        .clk_i      (eth_tx_clk_125m),
        .rst_i      (rst),
        .ptp_req_i  (ptp_req_q),
        .udp_req_i  (udp_req),
        .tx_done_i  (tx_done),
        .ptp_gnt_o  (ptp_gnt),
        .udp_gnt_o  (udp_gnt),
        .tx_sel_o   (tx_sel),
        .tx_start_o (tx_start_en)
    );

    assign t3_latch    = ptp_gnt;
    assign calc_en     = (state_q == ST_DONE);
    assign timeout_err = tout;
    assign ptp_state   = state_q;
    assign sequenceid  = seq_q;

endmodule

// File: tb/tb_ptp_delay_req_sched.sv
// Scoreboard bench for ptp_delay_req_sched. Each exchange scenario is planned
// from the timing rules as absolute cycle numbers; the expected output events
// are queued when planned and a separate monitor matches the DUT's pulses.
module tb_ptp_delay_req_sched;

    localparam int TO = 100;

    logic        eth_tx_clk_125m = 1'b0;
    logic        rst = 1'b1;
    logic        sync_rx = 1'b0, fup_rx = 1'b0, resp_rx = 1'b0;
    logic [15:0] resp_seqid = '0;
    logic        udp_req = 1'b0, tx_done = 1'b0;
    logic        udp_gnt, tx_sel, tx_start_en, t3_latch, calc_en, timeout_err;
    logic [15:0] sequenceid;
    logic [2:0]  ptp_state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [15:0] exp_seq = '0;
    bit          last_ptp = 1'b0;

    typedef struct {
        int          cyc;
        bit          sel;
        logic [15:0] seq;
        logic [2:0]  st;
    } ev_t;

    typedef struct {
        int          cyc;
        bit          is_seq;
        logic [15:0] val;
    } pr_t;

    // 0: tx_start_en, 1: calc_en, 2: timeout_err
    ev_t   evq[3][$];
    pr_t   prq[$];
    string knm[3] = '{"start", "calc", "tout"};

    ptp_delay_req_sched #(.TIMEOUT_CYC(32'd100), .SEQ_W(16)) dut (
        .eth_tx_clk_125m (eth_tx_clk_125m),
        .rst             (rst),
        .sync_rx         (sync_rx),
        .fup_rx          (fup_rx),
        .resp_rx         (resp_rx),
        .resp_seqid      (resp_seqid),
        .udp_req         (udp_req),
        .tx_done         (tx_done),
        .udp_gnt         (udp_gnt),
        .tx_sel          (tx_sel),
        .tx_start_en     (tx_start_en),
        .sequenceid      (sequenceid),
        .t3_latch        (t3_latch),
        .calc_en         (calc_en),
        .timeout_err     (timeout_err),
        .ptp_state       (ptp_state)
    );

    always #4 eth_tx_clk_125m = ~eth_tx_clk_125m;

    always @(posedge eth_tx_clk_125m) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s at cycle %0d: got=%0h want=%0h", name, cyc, got, want);
        end
    endtask

    function automatic void push_ev(int k, int c, bit sel, logic [15:0] seq, logic [2:0] st);
        ev_t e;
        int  i;
        e.cyc = c; e.sel = sel; e.seq = seq; e.st = st;
        i = evq[k].size();
        while (i > 0 && evq[k][i-1].cyc > c) i--;
        evq[k].insert(i, e);
    endfunction

    function automatic void push_pr(int c, bit is_seq, logic [15:0] val);
        pr_t p;
        int  i;
        p.cyc = c; p.is_seq = is_seq; p.val = val;
        i = prq.size();
        while (i > 0 && prq[i-1].cyc > c) i--;
        prq.insert(i, p);
    endfunction

    task automatic step();
        @(posedge eth_tx_clk_125m);
        #1;
    endtask

    // Monitor: matches output pulses and probes against the scoreboard.
    initial begin
        forever begin
            @(negedge eth_tx_clk_125m);
            if (rst) begin
                check("reset_outputs",
                      {9'd0, udp_gnt, tx_sel, tx_start_en, t3_latch, calc_en,
                       timeout_err, ptp_state, sequenceid}, 32'd0);
            end
            for (int k = 0; k < 3; k++) begin
                logic fired;
                ev_t  e;
                fired = (k == 0) ? tx_start_en : (k == 1) ? calc_en : timeout_err;
                while (evq[k].size() > 0 && evq[k][0].cyc < cyc) begin
                    check({knm[k], "_missing"}, cyc, evq[k][0].cyc);
                    void'(evq[k].pop_front());
                end
                if (fired) begin
                    if (evq[k].size() > 0 && evq[k][0].cyc == cyc) begin
                        e = evq[k].pop_front();
                        if (k == 0) begin
                            check("start_tx_sel", tx_sel, e.sel);
                            check("start_t3_latch", t3_latch, e.sel);
                            check("start_udp_gnt", udp_gnt, !e.sel);
                        end else if (k == 1) begin
                            check("calc_sequenceid", sequenceid, e.seq);
                            check("calc_state", ptp_state, 3'd5);
                        end else begin
                            check("tout_state", ptp_state, e.st);
                        end
                    end else begin
                        check({knm[k], "_unexpected"}, fired, 1'b0);
                    end
                end
            end
            while (prq.size() > 0 && prq[0].cyc <= cyc) begin
                pr_t p;
                p = prq.pop_front();
                if (p.is_seq) check("probe_sequenceid", sequenceid, p.val);
                else          check("probe_state", ptp_state, p.val);
            end
        end
    end

    // One exchange scenario. rmode: 0 response, 1 response timeout,
    // 2 new Sync during WAIT_RESP. umode: 0 none, 1 UDP owns the path before
    // Follow_Up, 2 UDP requests in the same cycle as the PTP request.
    task automatic run_exchange(input bit fup_to, input int restart_k, input int g_fup,
                                input int g_done, input int rmode, input int g_resp,
                                input bit bad_id, input int umode, input bit stray);
        int          b, s, s2, base2, f, p, d, r, a, u_on, u_off, ud, e, j;
        bit          tie_last, accept;
        logic [15:0] rid;
        s2 = -1; f = -1; p = -1; d = -1; r = -1; a = -1;
        u_on = -1; u_off = -1; ud = -1;
        rid = exp_seq;
        j = $urandom_range(0, 10);
        b = cyc + 1;
        s = b + 2;
        if (restart_k > 0) s2 = s + restart_k;
        base2 = (restart_k > 0) ? s2 : s;
        if (fup_to) begin
            push_ev(2, base2 + TO, 1'b0, '0, 3'd1);
            push_pr(base2 + TO + 1, 1'b0, 16'd0);
            e = base2 + TO + 1;
        end else begin
            f = base2 + g_fup;
            push_pr(f + 1, 1'b0, 16'd2);
            tie_last = last_ptp;
            case (umode)
                1: begin
                    u_on = s; u_off = s + 1;
                    push_ev(0, s, 1'b0, '0, '0);
                    ud = f + 1 + j;
                    p  = ud + 1;
                end
                2: begin
                    u_on = f + 2;
                    if (tie_last) begin
                        push_ev(0, f + 2, 1'b0, '0, '0);
                        u_off = f + 3;
                        ud    = f + 3 + j;
                        p     = ud + 1;
                    end else begin
                        p = f + 2;
                    end
                end
                default: p = f + 2;
            endcase
            exp_seq  = exp_seq + 16'd1;
            last_ptp = 1'b1;
            push_ev(0, p, 1'b1, '0, '0);
            push_pr(p + 1, 1'b0, 16'd3);
            push_pr(p + 1, 1'b1, exp_seq);
            d = p + g_done;
            if (umode == 2 && !tie_last) begin
                push_ev(0, d + 1, 1'b0, '0, '0);
                u_off    = d + 2;
                ud       = d + 2 + j;
                last_ptp = 1'b0;
            end
            case (rmode)
                0: begin
                    r   = d + 1 + g_resp;
                    rid = bad_id ? exp_seq - 16'd1 : exp_seq;
                    accept = 1'b1;
`ifdef PTP_SEQ_CHECK_EN
                    accept = !bad_id;
`endif
                    if (accept) begin
                        push_ev(1, r + 1, 1'b0, exp_seq, '0);
                        push_pr(r + 2, 1'b0, 16'd0);
                        e = r + 2;
                    end else begin
                        push_ev(2, d + TO, 1'b0, '0, 3'd4);
                        push_pr(d + TO + 1, 1'b0, 16'd0);
                        e = d + TO + 1;
                    end
                end
                1: begin
                    push_ev(2, d + TO, 1'b0, '0, 3'd4);
                    push_pr(d + TO + 1, 1'b0, 16'd0);
                    e = d + TO + 1;
                end
                default: begin
                    a = d + 1 + g_resp;
                    push_pr(a + 1, 1'b0, 16'd1);
                    push_ev(2, a + TO, 1'b0, '0, 3'd1);
                    push_pr(a + TO + 1, 1'b0, 16'd0);
                    e = a + TO + 1;
                end
            endcase
        end
        if (ud > e) e = ud;
        e = e + 3;
        while (cyc < e) begin
            step();
            sync_rx    = (cyc == s) || (cyc == s2) || (cyc == a);
            fup_rx     = (cyc == f);
            resp_rx    = (cyc == r);
            resp_seqid = rid;
            tx_done    = (cyc == d) || (cyc == ud) || (stray && cyc == b);
            udp_req    = (u_on >= 0) && (cyc >= u_on) && (cyc < u_off);
        end
    endtask

    // Reset while the Delay_Req frame is in flight, with a UDP request pending.
    task automatic run_reset_mid_frame();
        int s, f, p, e;
        s = cyc + 3;
        f = s + 5;
        p = f + 2;
        exp_seq = exp_seq + 16'd1;
        push_ev(0, p, 1'b1, '0, '0);
        push_pr(p + 1, 1'b0, 16'd3);
        e = p + 6;
        while (cyc < e) begin
            step();
            sync_rx = (cyc == s);
            fup_rx  = (cyc == f);
            udp_req = (cyc >= p + 2) && (cyc < e);
            if (cyc == p + 3) rst = 1'b1;
        end
        udp_req  = 1'b0;
        rst      = 1'b0;
        exp_seq  = '0;
        last_ptp = 1'b0;
        push_pr(cyc + 1, 1'b0, 16'd0);
        push_pr(cyc + 1, 1'b1, 16'd0);
        step(); step();
    endtask

    initial begin
        repeat (3) step();
        rst = 1'b0;
        push_pr(cyc + 1, 1'b1, 16'd0);
        push_pr(cyc + 1, 1'b0, 16'd0);
        step(); step();

        // Nominal exchange with test-plan spacing.
        run_exchange(1'b0, 0, 10, 18, 0, 19, 1'b0, 0, 1'b0);
        // Follow_Up timeout.
        run_exchange(1'b1, 0, 0, 0, 0, 0, 1'b0, 0, 1'b0);
        // UDP owns the path while Follow_Up arrives; stray tx_done while free.
        run_exchange(1'b0, 0, 8, 5, 0, 4, 1'b0, 1, 1'b1);
        // Tie right after a PTP grant: UDP first.
        run_exchange(1'b0, 0, 6, 4, 0, 3, 1'b0, 2, 1'b0);
        // Tie after a UDP grant: PTP first.
        run_exchange(1'b0, 0, 6, 4, 0, 3, 1'b0, 2, 1'b0);
        // Response in the same cycle as timer expiry.
        run_exchange(1'b0, 0, 3, 2, 0, 99, 1'b0, 0, 1'b0);
        // Mismatched response id.
        run_exchange(1'b0, 0, 3, 2, 0, 10, 1'b1, 0, 1'b0);
        // Response timeout, then abandon via new Sync.
        run_exchange(1'b0, 0, 3, 2, 1, 0, 1'b0, 0, 1'b0);
        run_exchange(1'b0, 0, 3, 2, 2, 7, 1'b0, 0, 1'b0);
        // Sync restart with Follow_Up in the same cycle.
        run_exchange(1'b0, 5, 0, 3, 0, 2, 1'b0, 0, 1'b0);

        // Sequence id wrap.
        step();
        force dut.seq_q = 16'hFFFF;
        step();
        release dut.seq_q;
        exp_seq = 16'hFFFF;
        push_pr(cyc + 1, 1'b1, 16'hFFFF);
        step();
        run_exchange(1'b0, 0, 4, 3, 0, 5, 1'b0, 0, 1'b0);

        run_reset_mid_frame();
        run_exchange(1'b0, 0, 4, 3, 0, 5, 1'b0, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            bit fto, bid, str;
            int rk, gf, gd, rm, gr, um, sel;
            fto = ($urandom_range(0, 7) == 0);
            rk  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 0;
            gf  = (rk > 0 && $urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, 50));
            gd  = $urandom_range(1, 20);
            sel = $urandom_range(0, 9);
            rm  = (sel < 7) ? 0 : (sel < 9) ? 1 : 2;
            gr  = (rm == 0 && $urandom_range(0, 5) == 0) ? 99 : int'($urandom_range(0, 60));
            bid = ($urandom_range(0, 4) == 0);
            um  = $urandom_range(0, 2);
            str = $urandom_range(0, 1);
            run_exchange(fto, rk, gf, gd, rm, gr, bid, um, str);
        end

        repeat (5) step();
        check("pending_events",
              evq[0].size() + evq[1].size() + evq[2].size() + prq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Cycle budget guard.
    initial begin
        wait (cyc > 90000);
        check("cycle_budget", cyc, 32'd90000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
